// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame buffer memory initiator.
// Holds the controller state encoding, the arbitration grant encoding and
// named strobe levels so active-low memory strobes read clearly at use sites.
package frame_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR1  = 2'd1,
        ST_WR2  = 2'd2,
        ST_RD   = 2'd3
    } state_e;

    // Records which direction won the most recent grant in IDLE.
    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

endpackage

// File: rtl/frame_addr_ctr.sv
// Wrapping frame pointer used for both the write and the read side.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   inc        : advance the pointer; wraps from FRAME_WORDS-1 to 0
//   clr        : return the pointer to 0 (wins over inc)
//   addr       : BASE_ADDR + pointer, modulo 2^ADDR_WIDTH
//   wrap       : high in the cycle an increment wraps the pointer
module frame_addr_ctr
    import frame_buf_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 29,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    FRAME_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wrap
);

    localparam int PTR_W = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_WORDS - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Clear has priority so an aborted frame always restarts at the base.
    always_comb begin
        ptr_d = ptr_q;
        wrap  = DEASSERT_H;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            if (ptr_q == LAST_PTR) begin
                ptr_d = '0;
                wrap  = ASSERT_H;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign addr = BASE_ADDR + ADDR_WIDTH'(ptr_q);

endmodule

// File: rtl/frame_buf_initiator.sv
// Memory-side initiator for the frame buffer: writes a pixel-word stream to
// sequential addresses of one frame region and reads whole frames back.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data  : write stream (in_ready is combinational)
//   rd_start, rd_busy          : start a frame readback / readback active
//   out_valid/out_ready/out_data : read word stream
//   wr_frame_done, rd_frame_done : one-cycle end-of-frame pulses
//   rd_timeout_err             : sticky read timeout flag
//   mem_*                      : active-low strobe memory interface
module frame_buf_initiator
    import frame_buf_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 29,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    FRAME_WORDS = 1024,
    parameter int                    RD_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  rd_start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  rd_busy,
    output logic                  wr_frame_done,
    output logic                  rd_frame_done,
    output logic                  rd_timeout_err,
    output logic                  mem_wr_en_n,
    output logic                  mem_rd_en_n,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_valid
);

    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    state_e                state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  wr_en_n_q, wr_en_n_d;
    logic                  rd_en_n_q, rd_en_n_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  rd_busy_q, rd_busy_d;
    logic                  wr_done_q, wr_done_d;
    logic                  rd_done_q, rd_done_d;
    logic                  tmo_err_q, tmo_err_d;

    logic                  wr_inc, rd_inc, rd_clr;
    logic                  wr_wrap, rd_wrap;
    logic [ADDR_WIDTH-1:0] wr_ptr_addr, rd_ptr_addr;
    logic                  wr_elig, rd_elig, grant_wr, grant_rd;

    frame_addr_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .FRAME_WORDS(FRAME_WORDS)
    ) u_wr_ctr (
        .clk  (clk),
        .reset(reset),
        .inc  (wr_inc),
        .clr  (1'b0),
        .addr (wr_ptr_addr),
        .wrap (wr_wrap)
    );

    frame_addr_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .FRAME_WORDS(FRAME_WORDS)
    ) u_rd_ctr (
        .clk  (clk),
        .reset(reset),
        .inc  (rd_inc),
        .clr  (rd_clr),
        .addr (rd_ptr_addr),
        .wrap (rd_wrap)
    );

    // Next-state logic. Strobes are registered and only fall on a grant from
    // IDLE, so there is always at least one IDLE cycle with both strobes high
    // between transactions and they can never be low together.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = '0;
        wr_en_n_d    = wr_en_n_q;
        rd_en_n_d    = rd_en_n_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_data_d    = wr_data_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        rd_busy_d    = rd_busy_q;
        wr_done_d    = DEASSERT_H;
        rd_done_d    = DEASSERT_H;
        tmo_err_d    = tmo_err_q;
        in_ready     = DEASSERT_H;
        wr_inc       = 1'b0;
        rd_inc       = 1'b0;
        rd_clr       = 1'b0;
        wr_elig      = in_valid;
        rd_elig      = rd_busy_q && !out_valid_q;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;

        // A start request while a frame is in flight is dropped, including
        // the cycle that completes or aborts the frame.
        if (rd_start && !rd_busy_q) begin
            rd_busy_d = ASSERT_H;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = DEASSERT_H;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_elig && rd_elig) begin
                    grant_wr = (last_grant_q == GRANT_RD);
                    grant_rd = (last_grant_q == GRANT_WR);
                end else begin
                    grant_wr = wr_elig;
                    grant_rd = rd_elig;
                end
                if (grant_wr) begin
                    in_ready     = ASSERT_H;
                    wr_data_d    = in_data;
                    wr_addr_d    = wr_ptr_addr;
                    wr_en_n_d    = ASSERT_L;
                    last_grant_d = GRANT_WR;
                    state_d      = ST_WR1;
                end else if (grant_rd) begin
                    rd_addr_d    = rd_ptr_addr;
                    rd_en_n_d    = ASSERT_L;
                    last_grant_d = GRANT_RD;
                    state_d      = ST_RD;
                end
            end
            ST_WR1: begin
                state_d = ST_WR2;
            end
            ST_WR2: begin
                wr_en_n_d = DEASSERT_L;
                wr_inc    = 1'b1;
                wr_done_d = wr_wrap;
                state_d   = ST_IDLE;
            end
            ST_RD: begin
                // Valid data wins over a timeout landing in the same cycle.
                if (mem_rd_data_valid) begin
                    out_data_d  = mem_rd_data;
                    out_valid_d = ASSERT_H;
                    rd_en_n_d   = DEASSERT_L;
                    rd_inc      = 1'b1;
                    state_d     = ST_IDLE;
                    if (rd_wrap) begin
                        rd_busy_d = DEASSERT_H;
                        rd_done_d = ASSERT_H;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_err_d = ASSERT_H;
                    rd_en_n_d = DEASSERT_L;
                    rd_busy_d = DEASSERT_H;
                    rd_clr    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset forces strobes high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_RD;
            tmo_cnt_q    <= '0;
            wr_en_n_q    <= DEASSERT_L;
            rd_en_n_q    <= DEASSERT_L;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_data_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= DEASSERT_H;
            rd_busy_q    <= DEASSERT_H;
            wr_done_q    <= DEASSERT_H;
            rd_done_q    <= DEASSERT_H;
            tmo_err_q    <= DEASSERT_H;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
            wr_en_n_q    <= wr_en_n_d;
            rd_en_n_q    <= rd_en_n_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_data_q    <= wr_data_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            rd_busy_q    <= rd_busy_d;
            wr_done_q    <= wr_done_d;
            rd_done_q    <= rd_done_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign mem_wr_en_n    = wr_en_n_q;
    assign mem_rd_en_n    = rd_en_n_q;
    assign mem_wr_addr    = wr_addr_q;
    assign mem_rd_addr    = rd_addr_q;
    assign mem_wr_data    = wr_data_q;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign rd_busy        = rd_busy_q;
    assign wr_frame_done  = wr_done_q;
    assign rd_frame_done  = rd_done_q;
    assign rd_timeout_err = tmo_err_q;

endmodule
